buzzer_alert_ctrl: RTL and testbench
====================================

# buzzer_alert_ctrl

Alert sequencer and arbiter for the buzzer PWM output stage. It accepts beep requests from up to NUM_REQ independent sources, such as ADC threshold alarms, keypress acknowledge and fault flags. It picks one request by fixed priority and plays it as a counted burst of timed beeps. It drives the `enable` input of the buzzer PWM generator and reports which source is sounding.

## Interface
- CLOCK_FREQ, 100_000_000: system clock in Hz.
- NUM_REQ, 4: number of requesters, 1..8.
- ON_MS, 100: beep on-time in ms, ≥1.
- OFF_MS, 100: silence after each beep in ms, ≥1.
- Derived: TICKS_PER_MS = CLOCK_FREQ/1000, must be ≥1. Phase lengths are ON_MS·TICKS_PER_MS and OFF_MS·TICKS_PER_MS cycles, exactly.

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  one-cycle request pulse per source; bit 0 has the highest priority.
- req_beeps  in  4·NUM_REQ  beep count for source i is in bits [4i+3:4i]; sampled in the same cycle as req[i].
- abort  in  1  cancels the current burst and all pending requests.
- buzzer_en  out  1  registered; drives the PWM `enable` input.
- busy  out  1  registered; high in every state except IDLE.
- active_id  out  max(1,$clog2(NUM_REQ))  index of the sounding source; 0 when idle.
- done  out  1  one-cycle pulse when a burst completes normally.

## Operation
- **Pending latches**
  - Each source has a pending bit and a 4-bit stored count.
  - When req[i] is high and req_beeps[i] ≠ 0, pending[i] is set and the count is stored; a later request overwrites the count.
  - A request with req_beeps[i] = 0 is ignored.
- **FSM states:** IDLE, ON, OFF.
  - IDLE → ON when any pending bit is set. The lowest set index is granted, its pending bit is cleared, its count is loaded into the remaining-beeps counter, and active_id is updated.
  - ON: buzzer_en = 1 for ON_MS·TICKS_PER_MS cycles, then the FSM goes to OFF and the remaining count is decremented.
  - OFF: buzzer_en = 0 for OFF_MS·TICKS_PER_MS cycles. Then, if remaining ≠ 0, the FSM goes to ON; otherwise it pulses done and goes to IDLE.
- **Arbitration:** non-preemptive. A higher-priority request that arrives mid-burst waits in its pending bit until the current burst ends.
- **Re-request by the active source** sets that source's pending bit again, so the burst replays after the current one.
- **Simultaneous req pulses** set all the corresponding pending bits; the sources are then served in index order, one burst each.
- **abort**
  - Clears all pending bits and returns the FSM to IDLE with buzzer_en = 0 on the next edge. No done pulse is issued.
  - abort takes precedence over a req in the same cycle, so that req is dropped.
- **Phase counter:** width $clog2(max(ON_MS,OFF_MS)·TICKS_PER_MS + 1). It is reloaded on every phase entry and never wraps mid-phase.
- **Reset** behaves like abort and also clears the stored counts. Reset takes precedence over everything else, including in the middle of a burst.

## Timing
- **Reset values:** buzzer_en = 0, busy = 0, active_id = 0, done = 0; state IDLE, all pending bits clear.
- **Request latency:** when req[i] is sampled at edge k with the FSM idle, pending is set at edge k, and buzzer_en, busy and active_id take effect after edge k+1.
- **Burst length:** a burst of N beeps keeps busy high for exactly N·(ON_MS+OFF_MS)·TICKS_PER_MS cycles.
- **done:** pulses in the single cycle after the last OFF phase ends, which is also the first cycle of IDLE.
- **Back-to-back bursts:** when another pending bit is set at the end of a burst, the FSM spends exactly one IDLE cycle, with busy = 0 and done = 1, before the next ON phase.
- **Downstream PWM:** buzzer_en edges are glitch-free. The PWM stage holds its output while disabled, so OFF phases are silent.

## Test plan
Bench parameters: CLOCK_FREQ=10_000 (TICKS_PER_MS=10), ON_MS=2, OFF_MS=3, NUM_REQ=4.
1. **Single burst:** req[2] with count 3 at cycle 5 → buzzer_en high for cycles 7–26, 57–76 and 107–126; busy high for cycles 7–156; done pulse at cycle 157; active_id = 2 throughout the burst.
2. **Priority and non-preemption:** req[3] with count 1, then req[0] with count 2 issued 10 cycles later → source 3 plays its burst to completion; after one IDLE cycle, source 0 plays 2 beeps with active_id = 0.
3. **Simultaneous requests:** req = 4'b0110 with counts 1 and 1 → source 1 plays first, then source 2; two done pulses in total.
4. **Abort:** abort asserted 15 cycles into the second beep of a 4-beep burst → buzzer_en = 0 and busy = 0 on the next edge; no done pulse; a req[1] pending before the abort never plays.
5. **Zero count and re-request:**
   - req[0] with count 0 → no activity.
   - req[1] issued again during its own burst → the burst replays once more after one IDLE cycle.
6. **Reset mid-ON:** reset asserted for 1 cycle during an ON phase → all outputs go to their reset values on the next edge; a subsequent req[0] with count 1 produces a normal burst.

Source files
------------

// File: rtl/buzzer_alert_ctrl.sv
// Buzzer alert sequencer: latches beep requests from NUM_REQ sources, grants them by
// fixed priority (bit 0 highest) and plays each as a counted burst of timed beeps.
module buzzer_alert_ctrl #(
    parameter int  CLOCK_FREQ = 100_000_000,
    parameter int  NUM_REQ    = 4,
    parameter int  ON_MS      = 100,
    parameter int  OFF_MS     = 100,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_beeps,
    input  logic                   abort,
    output logic                   buzzer_en,
    output logic                   busy,
    output logic [ID_W-1:0]        active_id,
    output logic                   done
);

    localparam int TICKS_PER_MS = CLOCK_FREQ / 1000;
    localparam int ON_TICKS     = ON_MS * TICKS_PER_MS;
    localparam int OFF_TICKS    = OFF_MS * TICKS_PER_MS;
    localparam int MAX_TICKS    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_W        = $clog2(MAX_TICKS + 1);

    // The counter runs load..0, so loading length-1 gives a phase of exactly length cycles.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   phase_cnt_reg, phase_cnt_next;
    logic [3:0]         remaining_reg, remaining_next;
    logic [ID_W-1:0]    active_id_reg, active_id_next;
    logic               done_reg, done_next;
    logic               buzzer_en_reg;
    logic               busy_reg;

    logic [NUM_REQ-1:0] pending_reg, pending_next;
    logic [3:0]         count_reg  [NUM_REQ];
    logic [3:0]         count_next [NUM_REQ];

    logic               grant_valid;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_take;

    // Fixed-priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign grant_valid = |pending_reg;

    // Per-source pending latch. A new request wins over the grant clear so the
    // active source can queue a replay of itself; abort drops everything.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
            logic [3:0] beeps_i;
            logic       load_i;
            logic       clear_i;

            assign beeps_i = req_beeps[4*gi +: 4];
            assign load_i  = req[gi] && (beeps_i != 4'd0) && !abort;
            assign clear_i = grant_take && (grant_idx == ID_W'(gi));

            assign pending_next[gi] = abort   ? 1'b0 :
                                      load_i  ? 1'b1 :
                                      clear_i ? 1'b0 : pending_reg[gi];
            assign count_next[gi]   = load_i ? beeps_i : count_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        remaining_next = remaining_reg;
        active_id_next = active_id_reg;
        done_next      = 1'b0;
        grant_take     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                active_id_next = '0;
                if (grant_valid) begin
                    state_next     = S_ON;
                    phase_cnt_next = ON_LOAD;
                    remaining_next = count_reg[grant_idx];
                    active_id_next = grant_idx;
                    grant_take     = 1'b1;
                end
            end
            S_ON: begin
                if (phase_cnt_reg == '0) begin
                    state_next     = S_OFF;
                    phase_cnt_next = OFF_LOAD;
                    remaining_next = remaining_reg - 4'd1;
                end else begin
                    phase_cnt_next = phase_cnt_reg - 1'b1;
                end
            end
            S_OFF: begin
                if (phase_cnt_reg == '0) begin
                    if (remaining_reg != 4'd0) begin
                        state_next     = S_ON;
                        phase_cnt_next = ON_LOAD;
                    end else begin
                        state_next     = S_IDLE;
                        active_id_next = '0;
                        done_next      = 1'b1;
                    end
                end else begin
                    phase_cnt_next = phase_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next     = S_IDLE;
                active_id_next = '0;
            end
        endcase

        // Abort silences immediately and never reports completion.
        if (abort) begin
            state_next     = S_IDLE;
            phase_cnt_next = '0;
            remaining_next = '0;
            active_id_next = '0;
            done_next      = 1'b0;
            grant_take     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            phase_cnt_reg <= '0;
            remaining_reg <= '0;
            active_id_reg <= '0;
            done_reg      <= 1'b0;
            buzzer_en_reg <= 1'b0;
            busy_reg      <= 1'b0;
            pending_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            remaining_reg <= remaining_next;
            active_id_reg <= active_id_next;
            done_reg      <= done_next;
            buzzer_en_reg <= (state_next == S_ON);
            busy_reg      <= (state_next != S_IDLE);
            pending_reg   <= pending_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                count_reg[i] <= 4'd0;
            end else begin
                count_reg[i] <= count_next[i];
            end
        end
    end

    assign buzzer_en = buzzer_en_reg;
    assign busy      = busy_reg;
    assign active_id = active_id_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_buzzer_alert_ctrl.sv
// Directed bench for buzzer_alert_ctrl: 20-cycle beeps, 30-cycle gaps; cycle n is
// the interval after rising edge n, inputs driven and outputs sampled 1 ns after it.
module tb_buzzer_alert_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_beeps;
    logic                 abort;
    logic                 buzzer_en;
    logic                 busy;
    logic [ID_W-1:0]      active_id;
    logic                 done;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] en_cnt, busy_cnt, done_cnt;

    buzzer_alert_ctrl #(
        .CLOCK_FREQ (10_000),
        .NUM_REQ    (NUM_REQ),
        .ON_MS      (2),
        .OFF_MS     (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_beeps (req_beeps),
        .abort     (abort),
        .buzzer_en (buzzer_en),
        .busy      (busy),
        .active_id (active_id),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        en_cnt   = en_cnt + 32'(buzzer_en);
        busy_cnt = busy_cnt + 32'(busy);
        done_cnt = done_cnt + 32'(done);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic clr_cnt();
        en_cnt   = 0;
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request during the current cycle.
    task automatic pulse_req(input logic [NUM_REQ-1:0] r, input logic [4*NUM_REQ-1:0] b);
        req       = r;
        req_beeps = b;
        tick();
        req       = '0;
        req_beeps = '0;
    endtask

    initial begin
        reset = 1'b1; req = '0; req_beeps = '0; abort = 1'b0;
        clr_cnt();
        tick(); tick();
        chk("rst_buzzer_en", buzzer_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active_id", active_id, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // 1: single burst, source 2, three beeps, request in cycle 5
        run_to(5); clr_cnt();
        pulse_req(4'b0100, 16'h0300);
        chk("t1_latency_busy", busy, 0);
        run_to(7);
        chk("t1_on_start", buzzer_en, 1);
        chk("t1_busy_start", busy, 1);
        chk("t1_id", active_id, 2);
        run_to(26);  chk("t1_on_end", buzzer_en, 1);
        run_to(27);  chk("t1_off_start", buzzer_en, 0);
        chk("t1_off_busy", busy, 1);
        run_to(56);  chk("t1_off_end", buzzer_en, 0);
        run_to(57);  chk("t1_beep2", buzzer_en, 1);
        chk("t1_id_mid", active_id, 2);
        run_to(107); chk("t1_beep3", buzzer_en, 1);
        run_to(126); chk("t1_beep3_end", buzzer_en, 1);
        run_to(127); chk("t1_beep3_off", buzzer_en, 0);
        run_to(156); chk("t1_busy_last", busy, 1);
        chk("t1_done_early", done, 0);
        run_to(157); chk("t1_done", done, 1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_id", active_id, 0);
        run_to(158); chk("t1_done_once", done, 0);
        chk("t1_en_cycles", en_cnt, 60);
        chk("t1_busy_cycles", busy_cnt, 150);
        chk("t1_done_count", done_cnt, 1);

        // 2: source 3 (1 beep) then higher-priority source 0 (2 beeps) arrives mid-burst
        run_to(200); clr_cnt();
        pulse_req(4'b1000, 16'h1000);
        run_to(210);
        pulse_req(4'b0001, 16'h0002);
        run_to(215); chk("t2_no_preempt_id", active_id, 3);
        chk("t2_no_preempt_en", buzzer_en, 1);
        run_to(222); chk("t2_off_id", active_id, 3);
        run_to(252); chk("t2_gap_done", done, 1);
        chk("t2_gap_busy", busy, 0);
        run_to(253); chk("t2_src0_on", buzzer_en, 1);
        chk("t2_src0_id", active_id, 0);
        chk("t2_src0_busy", busy, 1);
        run_to(303); chk("t2_src0_beep2", buzzer_en, 1);
        run_to(353); chk("t2_src0_done", done, 1);
        chk("t2_en_cycles", en_cnt, 60);
        chk("t2_done_count", done_cnt, 2);

        // 3: simultaneous requests from sources 1 and 2
        run_to(400); clr_cnt();
        pulse_req(4'b0110, 16'h0110);
        run_to(402); chk("t3_first_id", active_id, 1);
        run_to(452); chk("t3_gap_done", done, 1);
        run_to(453); chk("t3_second_id", active_id, 2);
        chk("t3_second_en", buzzer_en, 1);
        run_to(503); chk("t3_done2", done, 1);
        run_to(504); chk("t3_idle", busy, 0);
        chk("t3_done_count", done_cnt, 2);

        // 4: abort 15 cycles into the second beep; queued source 1 is dropped
        run_to(600); clr_cnt();
        pulse_req(4'b0001, 16'h0004);
        run_to(610);
        pulse_req(4'b0010, 16'h0020);
        run_to(667); chk("t4_pre_abort_en", buzzer_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_en", buzzer_en, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_id", active_id, 0);
        clr_cnt();
        run_to(800);
        chk("t4_no_replay_busy", busy_cnt, 0);
        chk("t4_no_done", done_cnt, 0);

        // 5a: zero-count request is ignored
        run_to(850); clr_cnt();
        pulse_req(4'b0001, 16'h0000);
        run_to(900); chk("t5_zero_busy", busy_cnt, 0);

        // 5b: source 1 re-requests itself during its own burst
        clr_cnt();
        pulse_req(4'b0010, 16'h0010);
        run_to(910);
        pulse_req(4'b0010, 16'h0010);
        run_to(952); chk("t5_gap_done", done, 1);
        chk("t5_gap_busy", busy, 0);
        run_to(953); chk("t5_replay_en", buzzer_en, 1);
        chk("t5_replay_id", active_id, 1);
        run_to(1003); chk("t5_replay_done", done, 1);
        run_to(1004); chk("t5_idle", busy, 0);
        chk("t5_en_cycles", en_cnt, 40);
        chk("t5_done_count", done_cnt, 2);

        // abort in the same cycle as a request drops the request
        run_to(1050); clr_cnt();
        req = 4'b1000; req_beeps = 16'h1000; abort = 1'b1;
        tick();
        req = '0; req_beeps = '0; abort = 1'b0;
        run_to(1080); chk("t5_abort_req_drop", busy_cnt, 0);

        // 6: reset during an ON phase, then a normal burst from source 0
        run_to(1100);
        pulse_req(4'b0100, 16'h0200);
        run_to(1110); chk("t6_pre_reset_en", buzzer_en, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_en", buzzer_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_id", active_id, 0);
        chk("t6_rst_done", done, 0);
        run_to(1120); clr_cnt();
        pulse_req(4'b0001, 16'h0001);
        run_to(1122); chk("t6_on", buzzer_en, 1);
        chk("t6_busy", busy, 1);
        run_to(1141); chk("t6_on_end", buzzer_en, 1);
        run_to(1142); chk("t6_off", buzzer_en, 0);
        run_to(1172); chk("t6_done", done, 1);
        run_to(1250);
        chk("t6_busy_cycles", busy_cnt, 50);
        chk("t6_done_count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
